// File: rtl/decode_issue_queue.sv
// Decode-to-execute issue queue: a small circular buffer of decoded bundles
// with a registered head output, flush squash and synchronous reset.
module decode_issue_queue #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    DEPTH       = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_PAYLOAD = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [DATA_WIDTH-1:0] head_reg, head_next;

    logic push;
    logic pop;

    // Handshake outputs depend only on registered state.
    assign in_ready  = (count_reg < FULL_COUNT);
    assign out_valid = (count_reg != '0);
    assign out_data  = head_reg;
    assign count     = count_reg;

    assign push = in_valid && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        head_next   = head_reg;

        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
            head_next   = NOP_PAYLOAD;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   count_next = count_reg + ONE_COUNT;
                2'b01:   count_next = count_reg - ONE_COUNT;
                default: count_next = count_reg;
            endcase

            // The next head is the incoming bundle when nothing older remains,
            // otherwise the stored entry at the advanced read pointer.
            if (count_next == '0) begin
                head_next = NOP_PAYLOAD;
            end else if ((count_reg == '0) || (pop && (count_reg == ONE_COUNT))) begin
                head_next = in_data;
            end else begin
                head_next = mem_reg[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= NOP_PAYLOAD;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    // Entry storage carries no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_reg[wr_ptr_reg] <= in_data;
        end
    end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_decode_issue_queue;

    localparam int DATA_WIDTH = 64;
    localparam int DEPTH      = 2;
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam logic [DATA_WIDTH-1:0] NOP = '0;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  flush = 1'b0;
    logic [CNT_W-1:0]      count;

    int errors = 0;
    int checks = 0;

    logic [DATA_WIDTH-1:0] model_q [$];

    decode_issue_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .NOP_PAYLOAD(NOP)
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_WIDTH-1:0] obs,
                         input logic [DATA_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [DATA_WIDTH-1:0] exp_head;
        exp_head = (model_q.size() > 0) ? model_q[0] : NOP;
        check({tag, ".count"},     DATA_WIDTH'(count),     DATA_WIDTH'(model_q.size()));
        check({tag, ".out_valid"}, DATA_WIDTH'(out_valid), DATA_WIDTH'(model_q.size() > 0));
        check({tag, ".in_ready"},  DATA_WIDTH'(in_ready),  DATA_WIDTH'(model_q.size() < DEPTH));
        check({tag, ".out_data"},  out_data,               exp_head);
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge from the pre-edge occupancy, then compare at the next falling edge.
    task automatic cycle(input string tag, input logic r, input logic f, input logic iv,
                         input logic [DATA_WIDTH-1:0] d, input logic ordy);
        int  occ;
        logic do_pop, do_push;
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        occ     = model_q.size();
        do_pop  = !r && !f && ordy && (occ > 0);
        do_push = !r && !f && iv && (occ < DEPTH);
        if (r || f) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        @(negedge clk);
        $display("%-10s rst=%0b fl=%0b iv=%0b d=%h ordy=%0b push=%0b pop=%0b -> cnt=%0d ov=%0b od=%h ir=%0b",
                 tag, r, f, iv, d, ordy, do_push, do_pop, count, out_valid, out_data, in_ready);
        check_outputs(tag);
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] held;
        @(negedge clk);

        // Reset two cycles, then a single push while execute stalls.
        cycle("reset", 1, 0, 0, 64'h0, 0);
        cycle("reset", 1, 0, 0, 64'h0, 0);
        cycle("push_a1", 0, 0, 1, 64'hA1, 0);

        // Fill to DEPTH, offer a third bundle that must be refused, then drain.
        cycle("push_a2", 0, 0, 1, 64'hA2, 0);
        cycle("full_a3", 0, 0, 1, 64'hA3, 0);
        cycle("full_a3", 0, 0, 1, 64'hA3, 0);
        cycle("pop_full", 0, 0, 1, 64'hA3, 1);
        cycle("push_a3", 0, 0, 1, 64'hA3, 1);
        cycle("drain", 0, 0, 0, 64'h0, 1);
        cycle("drain", 0, 0, 0, 64'h0, 1);

        // Streaming: one push and one pop per cycle, pointers wrap repeatedly.
        for (int i = 1; i <= 16; i++) begin
            cycle("stream", 0, 0, 1, DATA_WIDTH'(i), 1);
        end
        cycle("drain", 0, 0, 0, 64'h0, 1);

        // Flush with a simultaneous push and pop; 0xB0 must never surface.
        cycle("fill", 0, 0, 1, 64'h11, 0);
        cycle("fill", 0, 0, 1, 64'h22, 0);
        cycle("flush_b0", 0, 1, 1, 64'hB0, 1);
        cycle("post_fl", 0, 0, 1, 64'h33, 0);
        cycle("post_fl", 0, 0, 0, 64'h0, 1);
        cycle("post_fl", 0, 0, 0, 64'h0, 1);

        // Reset and flush together, then a push visible one cycle later.
        cycle("one", 0, 0, 1, 64'h44, 0);
        cycle("rst_fl", 1, 1, 1, 64'h55, 1);
        cycle("push_c0", 0, 0, 1, 64'hC0, 0);

        // Stall: head must stay put for five cycles.
        held = 64'hC0;
        for (int i = 0; i < 5; i++) begin
            cycle("stall", 0, 0, 0, 64'h0, 0);
            check("stall.hold", out_data, held);
        end
        cycle("drain", 0, 0, 0, 64'h0, 1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            logic r, f, iv, ordy;
            logic [DATA_WIDTH-1:0] d;
            r    = ($urandom_range(0, 63) == 0);
            f    = ($urandom_range(0, 15) == 0);
            iv   = $urandom_range(0, 1) == 1;
            ordy = $urandom_range(0, 3) != 0;
            d    = {$urandom, $urandom};
            cycle("rand", r, f, iv, d, ordy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_queue.md
DECODE_ISSUE_QUEUE -- requirements
Module: decode_issue_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of one decoded-instruction bundle (instruction, operands, control bits, addresses, offset).
REQ-002 Parameter DEPTH, default 2: number of bundle entries; power of two, >= 2.
REQ-003 Parameter NOP_PAYLOAD, default 0 (DATA_WIDTH bits): bundle presented on out_data when no valid entry is at the head.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  decode presents a bundle.
REQ-008 in_ready  out  1  queue accepts a bundle this cycle.
REQ-009 in_data  in  DATA_WIDTH  bundle from decode.
REQ-010 out_valid  out  1  head entry is valid for execute.
REQ-011 out_ready  in  1  execute consumes the head this cycle (stall when 0).
REQ-012 out_data  out  DATA_WIDTH  head bundle; NOP_PAYLOAD when out_valid=0.
REQ-013 flush  in  1  branch/exception squash; discards all entries.
REQ-014 count  out  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-015 Push occurs on a rising edge iff in_valid=1, in_ready=1 and flush=0.
REQ-016 Pop occurs on a rising edge iff out_valid=1, out_ready=1 and flush=0.
REQ-017 in_ready SHALL be 1 iff count < DEPTH; it is a function of registered state only, with no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 iff count > 0; out_data SHALL be driven from a registered head entry, with no combinational path from in_data.
REQ-019 Latency: a bundle pushed into an empty queue appears on out_data with out_valid=1 in the next cycle.
REQ-020 Ordering: bundles leave strictly in push order.
REQ-021 Storage: circular buffer with log2(DEPTH)-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-022 Count update: push only gives +1; pop only gives -1; simultaneous push and pop leaves count unchanged and advances both pointers.
REQ-023 Full (count=DEPTH): in_ready=0; an in_valid bundle is not accepted and decode must hold it. A pop in the same cycle frees an entry, but in_ready rises only in the next cycle.
REQ-024 Empty (count=0): a pop cannot occur, and out_data=NOP_PAYLOAD.
REQ-025 Flush: on an edge with flush=1, count, read pointer and write pointer all go to 0. Flush overrides any push or pop in the same cycle, and the in_data bundle of that cycle is discarded.
REQ-026 After a flush, out_valid=0 and out_data=NOP_PAYLOAD in the following cycle; a push is accepted in that cycle.
REQ-027 While out_valid=1 and out_ready=0, out_data SHALL hold stable until a pop, flush or reset.
REQ-028 Entry storage needs no reset; only pointers and count are reset.

Reset
REQ-029 On an edge with reset=1: count=0, both pointers=0, out_valid=0, in_ready=1, out_data=NOP_PAYLOAD.
REQ-030 Reset takes priority over flush, push and pop.
REQ-031 Reset asserted mid-operation discards all entries, with the same response as REQ-029 in the next cycle.

Verification
REQ-032 Bench: reset 2 cycles, then push 0xA1 with out_ready=0 -> next cycle out_valid=1, out_data=0xA1, count=1.
REQ-033 Bench (DEPTH=2): push 0xA1, 0xA2, then offer 0xA3 with out_ready=0 -> in_ready=0, count=2, 0xA3 not accepted; with out_ready=1 the outputs are 0xA1, 0xA2, 0xA3 in order.
REQ-034 Bench: continuous in_valid=1 and out_ready=1 streaming 0x01..0x10 -> one pop per cycle after the first, count stays 1, pointers wrap, order is preserved.
REQ-035 Bench: count=2, then flush=1 together with in_valid=1 (0xB0) and out_ready=1 -> next cycle count=0, out_valid=0, out_data=NOP_PAYLOAD, and 0xB0 never appears.
REQ-036 Bench: count=1, then reset=1 and flush=1 in the same cycle -> next cycle state as REQ-029; a push of 0xC0 after reset is output 1 cycle later.
REQ-037 Bench: stall with out_ready=0 for 5 cycles while out_valid=1 -> out_data constant, count unchanged.
